// File: rtl/rle_pkg.sv
// Shared definitions for the run-length image path (encoder and decoder sides).
package rle_pkg;
  localparam int DEFAULT_PIX_W = 8;
  localparam int DEFAULT_RUN_W = 6;
  localparam int DEFAULT_IDX_W = 6;
  localparam int BLOCK_PIXELS  = 2 ** DEFAULT_IDX_W;

  typedef enum logic {
    IDLE,
    EMIT
  } state_t;
endpackage

// File: rtl/rle_run_counter.sv
// Loadable down-counter holding the number of beats remaining in the current run.
module rle_run_counter #(
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_value,
  input  logic         dec,
  output logic         zero
);
  logic [W-1:0] count_reg;

  // A load takes priority so a reload on the final beat never loses the new run.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= load_value;
    end else if (dec && (count_reg != '0)) begin
      count_reg <= count_reg - W'(1);
    end
  end

  assign zero = (count_reg == '0);
endmodule

// File: rtl/rle_block_decoder.sv
// Expands (symbol, run) pairs into an indexed pixel stream.
// Define ERR_CHECK_EN to truncate runs at the block end and flag overruns on err.
module rle_block_decoder
  import rle_pkg::*;
#(
  parameter int PIX_W = DEFAULT_PIX_W,
  parameter int RUN_W = DEFAULT_RUN_W,
  parameter int IDX_W = DEFAULT_IDX_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [PIX_W-1:0] in_symbol,
  input  logic [RUN_W-1:0] in_run,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [PIX_W-1:0] out_pixel,
  output logic [IDX_W-1:0] out_idx,
  output logic             block_done,
  output logic             err
);
  state_t           state_reg;
  logic             rem_zero;
  logic             beat;
  logic             last_beat;
  logic             accept;
  logic [RUN_W-1:0] load_value;

  assign beat       = out_valid && out_ready;
  assign last_beat  = beat && rem_zero;
  assign in_ready   = (state_reg == IDLE) || ((state_reg == EMIT) && rem_zero && out_ready);
  assign accept     = in_valid && in_ready;
  assign block_done = out_valid && (&out_idx);

`ifdef ERR_CHECK_EN
  localparam int BLOCK_SIZE = 2 ** IDX_W;
  localparam int SUM_W      = ((IDX_W > RUN_W) ? IDX_W : RUN_W) + 1;

  logic [IDX_W-1:0] start_idx;
  logic             overrun;

  // A reload on the last beat starts one position past the beat being emitted.
  assign start_idx  = (state_reg == EMIT) ? (out_idx + IDX_W'(1)) : out_idx;
  assign overrun    = (SUM_W'(start_idx) + SUM_W'(in_run)) >= SUM_W'(BLOCK_SIZE);
  // Remaining-minus-one up to the block end is simply the complement of the start index.
  assign load_value = overrun ? RUN_W'(~start_idx) : in_run;

  always_ff @(posedge clk) begin
    if (rst) begin
      err <= 1'b0;
    end else if (accept && overrun) begin
      err <= 1'b1;
    end
  end
`else
  assign load_value = in_run;
  assign err        = 1'b0;
`endif

  rle_run_counter #(
    .W(RUN_W)
  ) u_run_counter (
    .clk       (clk),
    .rst       (rst),
    .load      (accept),
    .load_value(load_value),
    .dec       (beat),
    .zero      (rem_zero)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      out_valid <= 1'b0;
      out_pixel <= '0;
      out_idx   <= '0;
    end else begin
      if (beat) begin
        out_idx <= out_idx + IDX_W'(1);
      end
      if (accept) begin
        out_pixel <= in_symbol;
      end
      case (state_reg)
        IDLE: begin
          if (accept) begin
            state_reg <= EMIT;
            out_valid <= 1'b1;
          end
        end
        EMIT: begin
          if (last_beat && !accept) begin
            state_reg <= IDLE;
            out_valid <= 1'b0;
          end
        end
        default: begin
          state_reg <= IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_rle_block_decoder.sv
// Scoreboard bench for rle_block_decoder: directed pairs, monitor checks every output beat.
module tb_rle_block_decoder;
  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_symbol;
  logic [5:0] in_run;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_pixel;
  logic [5:0] out_idx;
  logic       block_done;
  logic       err;

  typedef struct packed {
    logic [7:0] pix;
    logic [5:0] idx;
    logic       done;
  } beat_t;

  beat_t exp_q[$];
  int    checks = 0;
  int    errors = 0;
  int    cyc = 0;
  bit    mon_en = 1'b0;
  bit    stall_en = 1'b0;
  int    model_idx = 0;
  bit    exp_err = 1'b0;
  int    last_accept_cyc = 0;
  int    c0;

  rle_block_decoder dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_symbol (in_symbol),
    .in_run    (in_run),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_pixel (out_pixel),
    .out_idx   (out_idx),
    .block_done(block_done),
    .err       (err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Monitor: pops one expected beat per handshake, and checks outputs hold while stalled.
  initial begin : monitor
    beat_t got;
    beat_t want;
    beat_t held;
    bit    stalled;
    stalled = 1'b0;
    held = '0;
    forever begin
      @(negedge clk);
      if (!mon_en) begin
        stalled = 1'b0;
      end else begin
        got = {out_pixel, out_idx, block_done};
        if (stalled) begin
          check("hold_valid", {31'd0, out_valid}, 32'd1);
          check("hold_beat", {17'd0, got}, {17'd0, held});
        end
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL extra_beat: got pix %0h idx %0d, expected no beat", out_pixel, out_idx);
          end else begin
            want = exp_q.pop_front();
            check("beat", {17'd0, got}, {17'd0, want});
          end
          stalled = 1'b0;
        end else if (out_valid) begin
          stalled = 1'b1;
          held = got;
        end else begin
          stalled = 1'b0;
        end
      end
    end
  end

  initial begin : stall_gen
    forever begin
      @(posedge clk);
      #1;
      if (stall_en) out_ready = 1'($urandom_range(0, 1));
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic push_run(input logic [7:0] sym, input logic [5:0] run);
    int len;
    len = int'(run) + 1;
`ifdef ERR_CHECK_EN
    if (model_idx + len > 64) begin
      len = 64 - model_idx;
      exp_err = 1'b1;
    end
`endif
    for (int i = 0; i < len; i++) begin
      exp_q.push_back({sym, 6'(model_idx), (model_idx == 63)});
      model_idx = (model_idx + 1) % 64;
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send_pair(input logic [7:0] sym, input logic [5:0] run);
    bit ok;
    ok = 1'b0;
    push_run(sym, run);
    in_symbol = sym;
    in_run    = run;
    in_valid  = 1'b1;
    for (int t = 0; t < 1000; t++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL accept_timeout: in_ready never high for pair %0h/%0d", sym, run);
    end
    @(posedge clk);
    last_accept_cyc = cyc;
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    for (int t = 0; t < 2000; t++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !out_valid) break;
    end
    check(name, exp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    mon_en = 1'b0;
    rst = 1'b1;
    repeat (n) @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    model_idx = 0;
    exp_err = 1'b0;
    @(negedge clk);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_idx", {26'd0, out_idx}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_block_done", {31'd0, block_done}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    @(posedge clk);
    #1;
    mon_en = 1'b1;
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_symbol = '0;
    in_run    = '0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    do_reset(3);

    // Single run of four pixels, then back to idle
    send_pair(8'h5A, 6'd3);
    drain("t2_drain");
    @(negedge clk);
    check("t2_idle_ready", {31'd0, in_ready}, 32'd1);
    check("t2_idle_valid", {31'd0, out_valid}, 32'd0);
    check("t2_idx", {26'd0, out_idx}, 32'd4);
    @(posedge clk);
    #1;

    // Reset held three cycles in the middle of a run
    send_pair(8'h11, 6'd20);
    repeat (5) @(posedge clk);
    #1;
    do_reset(3);

    // Two 32-pixel runs back-to-back, reload on the last beat of the first
    send_pair(8'h10, 6'd31);
    c0 = last_accept_cyc;
    send_pair(8'h20, 6'd31);
    check("t3_b2b_gap", last_accept_cyc - c0, 32);
    drain("t3_drain");

    // Sixty-four single-pixel runs, one beat per cycle
    for (int i = 0; i < 64; i++) begin
      send_pair(8'(i + 8'h40), 6'd0);
      if (i == 0) c0 = last_accept_cyc;
    end
    check("t6_gap", last_accept_cyc - c0, 63);
    drain("t6_drain");

    // Random output stalls during an 8-pixel run
    stall_en = 1'b1;
    send_pair(8'h77, 6'd7);
    drain("t4_drain");
    stall_en  = 1'b0;
    out_ready = 1'b1;

    // Advance to index 60, then a run that crosses the block end
    send_pair(8'h33, 6'd51);
    drain("t5_fill_drain");
    @(negedge clk);
    check("t5_idx60", {26'd0, out_idx}, 32'd60);
    @(posedge clk);
    #1;
    send_pair(8'hAA, 6'd7);
    send_pair(8'h5B, 6'd1);
    drain("t5_drain");
    @(negedge clk);
    check("t5_err", {31'd0, err}, {31'd0, exp_err});
    check("t5_final_idx", {26'd0, out_idx}, model_idx);
    @(posedge clk);
    #1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
